// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the register file and its writeback queue.
package mips_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for pending register writes; exposes every entry so the owner can
// search all in-flight results.
module wb_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [ADDR_W-1:0]             push_rd_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [CntW-1:0]               count_o,
  output logic [PtrW-1:0]               head_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  rd_o,
  output logic [DEPTH-1:0][DATA_W-1:0]  data_o
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PtrW-1:0]              wptr_q, wptr_d;
  logic [PtrW-1:0]              rptr_q, rptr_d;
  logic [CntW-1:0]              count_q, count_d;
  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic                         do_push, do_pop;

  // Guarded here as well so the buffer can never overrun whatever the caller does.
  assign do_push = push_i && (count_q != CntW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    valid_d = valid_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_q[wptr_q]   <= push_rd_i;
      data_q[wptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = rptr_q;
  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: arbitrates ALU/load results into an in-order buffer, drains one
// register-file write per cycle and offers a bypass lookup on both read ports.
module writeback_queue import mips_pkg::*; #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] lk_addr_1,
  output logic              lk_hit_1,
  output logic [DATA_W-1:0] lk_data_1,
  input  logic [ADDR_W-1:0] lk_addr_2,
  output logic              lk_hit_2,
  output logic [DATA_W-1:0] lk_data_2,
  output logic [CntW-1:0]   count
);

  localparam logic [ADDR_W-1:0] RegZero = ADDR_W'(REG_ZERO);

  logic                         space;
  logic                         sel_ld, sel_alu;
  logic                         push;
  logic [ADDR_W-1:0]            push_rd;
  logic [DATA_W-1:0]            push_data;
  logic [PtrW-1:0]              head;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PtrW-1:0]              idx;

  assign space     = (count != CntW'(DEPTH));
  assign ld_ready  = space;
  assign alu_ready = space && !ld_valid;

  assign sel_ld    = ld_valid && ld_ready;
  assign sel_alu   = alu_valid && alu_ready;
  assign push_rd   = sel_ld ? ld_rd : alu_rd;
  assign push_data = sel_ld ? ld_data : alu_data;
  // R0 writes still handshake but are dropped, mirroring the register file.
  assign push      = (sel_ld || sel_alu) && (push_rd != RegZero);

  assign rf_we    = (count != '0);
  assign rf_waddr = rf_we ? ent_rd[head] : '0;
  assign rf_wdata = rf_we ? ent_data[head] : '0;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_rd_i   (push_rd),
    .push_data_i (push_data),
    .pop_i       (rf_we),
    .count_o     (count),
    .head_o      (head),
    .valid_o     (ent_valid),
    .rd_o        (ent_rd),
    .data_o      (ent_data)
  );

  // Walk oldest to youngest from the head so the last match is the youngest value.
  always_comb begin
    lk_hit_1  = 1'b0;
    lk_data_1 = '0;
    lk_hit_2  = 1'b0;
    lk_data_2 = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PtrW'(k);
      if (ent_valid[idx] && (lk_addr_1 != RegZero) && (ent_rd[idx] == lk_addr_1)) begin
        lk_hit_1  = 1'b1;
        lk_data_1 = ent_data[idx];
      end
      if (ent_valid[idx] && (lk_addr_2 != RegZero) && (ent_rd[idx] == lk_addr_2)) begin
        lk_hit_2  = 1'b1;
        lk_data_2 = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed vector table, hand sequences and
// random traffic against a queue-based reference model.
module tb_writeback_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, ld_valid, ld_ready;
  logic [2:0]  alu_rd, ld_rd, rf_waddr, lk_addr_1, lk_addr_2;
  logic [15:0] alu_data, ld_data, rf_wdata, lk_data_1, lk_data_2;
  logic        rf_we, lk_hit_1, lk_hit_2;
  logic [2:0]  count;

  always #5 clk = ~clk;

  writeback_queue #(
    .DATA_W (16),
    .ADDR_W (3),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .lk_addr_1 (lk_addr_1),
    .lk_hit_1  (lk_hit_1),
    .lk_data_1 (lk_data_1),
    .lk_addr_2 (lk_addr_2),
    .lk_hit_2  (lk_hit_2),
    .lk_data_2 (lk_data_2),
    .count     (count)
  );

  typedef struct {
    logic        r;
    logic        lv;
    logic [2:0]  lrd;
    logic [15:0] ldd;
    logic        av;
    logic [2:0]  ard;
    logic [15:0] ad;
    logic [2:0]  a1;
    logic [2:0]  a2;
    bit          has_exp;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        ldr;
    logic        alur;
    logic [2:0]  cnt;
    logic        h1;
    logic [15:0] d1;
    logic        h2;
    logic [15:0] d2;
  } vec_t;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] wlog[$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [16:0] model_lk(input logic [2:0] a);
    logic [16:0] r;
    r = '0;
    if (a != 3'd0) begin
      foreach (mq[i]) if (mq[i].rd == a) r = {1'b1, mq[i].data};
    end
    return r;
  endfunction

  // One cycle: drive inputs, compare before the edge, then advance the model.
  task automatic step(input vec_t v);
    logic        m_ldr, m_alur, m_we;
    logic [16:0] m1, m2;
    ent_t        hd;
    rst = v.r;  ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ldd;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lk_addr_1 = v.a1; lk_addr_2 = v.a2;
    #2;
    m_ldr  = (mq.size() < DEPTH);
    m_alur = m_ldr && !v.lv;
    m_we   = (mq.size() != 0);
    hd.rd = 3'd0; hd.data = 16'd0;
    if (m_we) hd = mq[0];
    m1 = model_lk(v.a1);
    m2 = model_lk(v.a2);
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, hd.rd);
    chk("rf_wdata", rf_wdata, hd.data);
    chk("ld_ready", ld_ready, m_ldr);
    chk("alu_ready", alu_ready, m_alur);
    chk("count", count, mq.size());
    chk("lk_hit_1", lk_hit_1, m1[16]);
    chk("lk_data_1", lk_data_1, m1[15:0]);
    chk("lk_hit_2", lk_hit_2, m2[16]);
    chk("lk_data_2", lk_data_2, m2[15:0]);
    if (v.has_exp) begin
      chk("vec_rf_we", rf_we, v.we);
      chk("vec_rf_waddr", rf_waddr, v.waddr);
      chk("vec_rf_wdata", rf_wdata, v.wdata);
      chk("vec_ld_ready", ld_ready, v.ldr);
      chk("vec_alu_ready", alu_ready, v.alur);
      chk("vec_count", count, v.cnt);
      chk("vec_lk_hit_1", lk_hit_1, v.h1);
      chk("vec_lk_data_1", lk_data_1, v.d1);
      chk("vec_lk_hit_2", lk_hit_2, v.h2);
      chk("vec_lk_data_2", lk_data_2, v.d2);
    end
    if (rf_we) wlog.push_back(rf_wdata);
    @(posedge clk);
    if (v.r) begin
      mq.delete();
    end else begin
      if (m_we) void'(mq.pop_front());
      if (v.lv && m_ldr) begin
        if (v.lrd != 3'd0) mq.push_back('{rd: v.lrd, data: v.ldd});
      end else if (v.av && m_alur && v.ard != 3'd0) begin
        mq.push_back('{rd: v.ard, data: v.ad});
      end
    end
    #1;
  endtask

  function automatic vec_t idle(input logic [2:0] a1, input logic [2:0] a2);
    vec_t v;
    v = '{default: '0};
    v.a1 = a1;
    v.a2 = a2;
    return v;
  endfunction

  function automatic vec_t alu(input logic [2:0] rd, input logic [15:0] d, input logic [2:0] a1);
    vec_t v;
    v = idle(a1, 3'd0);
    v.av = 1'b1; v.ard = rd; v.ad = d;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    vec_t v;
    int   hits_bad;

    rst = 1'b1; ld_valid = 1'b0; alu_valid = 1'b0;
    ld_rd = '0; ld_data = '0; alu_rd = '0; alu_data = '0; lk_addr_1 = '0; lk_addr_2 = '0;
    repeat (2) @(posedge clk);
    #1;

    //        r lv lrd ldd       av ard ad         a1 a2 ex we wa wdata     lr ar cn h1 d1        h2 d2
    tbl[0] = '{0, 1, 3, 16'h00AA, 0, 0, 16'h0000,  3, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0};
    tbl[1] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000,  3, 0, 1, 1, 3, 16'h00AA, 1, 1, 1, 1, 16'h00AA, 0, 0};
    tbl[2] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000,  3, 0, 1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0};
    tbl[3] = '{0, 1, 1, 16'h0011, 1, 2, 16'h0022,  2, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0};
    tbl[4] = '{0, 0, 0, 16'h0000, 1, 2, 16'h0022,  1, 2, 1, 1, 1, 16'h0011, 1, 1, 1, 1, 16'h0011, 0, 0};
    tbl[5] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000,  2, 1, 1, 1, 2, 16'h0022, 1, 1, 1, 1, 16'h0022, 0, 0};
    tbl[6] = '{0, 0, 0, 16'h0000, 1, 0, 16'hFFFF,  0, 0, 1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0};
    tbl[7] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0};
    tbl[8] = '{0, 1, 0, 16'h1234, 1, 0, 16'hFFFF,  0, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0};
    tbl[9] = '{0, 0, 0, 16'h0000, 1, 0, 16'hFFFF,  0, 0, 1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0};

    wlog.delete();
    for (int i = 0; i < 10; i++) step(tbl[i]);
    chk("dir_write_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("dir_write0", wlog[0], 16'h00AA);
      chk("dir_write1", wlog[1], 16'h0011);
      chk("dir_write2", wlog[2], 16'h0022);
    end

    // Back-to-back writes to r5 with the drain running: order and bypass of youngest value.
    wlog.delete();
    for (int i = 1; i <= 4; i++) step(alu(3'd5, 16'(i), 3'd5));
    step(idle(3'd5, 3'd5));
    step(idle(3'd5, 3'd5));
    chk("r5_write_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("r5_order", wlog[i], 16'(i + 1));
    end

    // Reset discards pending work; nothing reaches the register file afterwards.
    step(alu(3'd6, 16'h0C0C, 3'd6));
    v = alu(3'd4, 16'h0BAD, 3'd4);
    v.r = 1'b1;
    step(v);
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      step(idle(3'd4, 3'd6));
      chk("post_rst_we", rf_we, 1'b0);
    end
    chk("post_rst_writes", wlog.size(), 0);

    // Random traffic with occasional reset.
    hits_bad = 0;
    for (int i = 0; i < 400; i++) begin
      v = '{default: '0};
      v.r   = ($urandom_range(0, 39) == 0);
      v.lv  = ($urandom_range(0, 2) == 0);
      v.lrd = 3'($urandom_range(0, 7));
      v.ldd = 16'($urandom);
      v.av  = ($urandom_range(0, 1) == 0);
      v.ard = 3'($urandom_range(0, 7));
      v.ad  = 16'($urandom);
      v.a1  = 3'($urandom_range(0, 7));
      v.a2  = 3'($urandom_range(0, 7));
      step(v);
    end

    rst = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
